// File: rtl/cmd_fill_engine.sv
// Screen RAM command executor: clears the screen or fills a span of
// words through RAM port A, one write per clock.
module cmd_fill_engine #(
    parameter int         ADDR_W     = 16,
    parameter int         MEM_WORDS  = 2400,
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              request,
    input  logic [7:0]        command,
    input  logic [ADDR_W-1:0] user_addr,
    input  logic [7:0]        fill_data,
    input  logic [ADDR_W-1:0] fill_len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wren,
    output logic              active,
    output logic              done,
    output logic              err
);

    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_FILL  = 8'h02;

    localparam logic [ADDR_W-1:0] WORDS = ADDR_W'(MEM_WORDS);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(MEM_WORDS - 1);
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        ERR
    } state_t;

    state_t            state;
    logic              r1, r2, r3;
    logic              req_edge;
    logic              err_pend;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] len_eff;

    // Oversized spans are clamped so no word is written twice.
    assign len_eff = (fill_len > WORDS) ? WORDS : fill_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1       <= 1'b1;
            r2       <= 1'b1;
            r3       <= 1'b1;
            req_edge <= 1'b0;
            err_pend <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_wren <= 1'b0;
            active   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            r1       <= request;
            r2       <= r1;
            r3       <= r2;
            req_edge <= r2 & ~r3;
            done     <= 1'b0;
            err      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_edge) begin
                        if (command == CMD_NOP) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (command == CMD_CLEAR) begin
                            state    <= RUN;
                            mem_addr <= '0;
                            mem_data <= CLEAR_CHAR;
                            mem_wren <= 1'b1;
                            active   <= 1'b1;
                            cnt      <= LAST;
                        end else if (command == CMD_FILL &&
                                     user_addr < WORDS) begin
                            if (len_eff == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state    <= RUN;
                                mem_addr <= user_addr;
                                mem_data <= fill_data;
                                mem_wren <= 1'b1;
                                active   <= 1'b1;
                                cnt      <= len_eff - ONE;
                            end
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // A busy reject landing on the done cycle is held back one clock.
                    if (req_edge) begin
                        if (cnt == '0) err_pend <= 1'b1;
                        else           err      <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        mem_wren <= 1'b0;
                        active   <= 1'b0;
                    end else begin
                        cnt      <= cnt - ONE;
                        mem_addr <= (mem_addr == LAST) ? '0 : mem_addr + ONE;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    err      <= req_edge | err_pend;
                    err_pend <= 1'b0;
                end
                ERR: begin
                    state <= IDLE;
                    err   <= req_edge;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_fill_engine.sv
// Self-checking bench for cmd_fill_engine: directed vector table,
// hand sequences for reset/busy corners, and randomized fills.
module tb_cmd_fill_engine;

    localparam int         MEM = 2400;
    localparam logic [7:0] CLR = 8'h20;

    logic        clk = 1'b0;
    logic        rst;
    logic        request;
    logic [7:0]  command;
    logic [15:0] user_addr;
    logic [7:0]  fill_data;
    logic [15:0] fill_len;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wren;
    logic        active;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    cmd_fill_engine #(
        .ADDR_W(16),
        .MEM_WORDS(MEM),
        .CLEAR_CHAR(CLR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .request(request),
        .command(command),
        .user_addr(user_addr),
        .fill_data(fill_data),
        .fill_len(fill_len),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_wren(mem_wren),
        .active(active),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] c;
        int         a;
        logic [7:0] d;
        int         l;
        int         busy;
        int         exp_n;
        int         exp_s;
        bit         exp_e;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: which words a command should write, from the command rules.
    function automatic void model(input logic [7:0] c, input int a,
                                  input int l, output int n,
                                  output int s, output bit e);
        n = 0;
        s = 0;
        e = 1'b0;
        if (c == 8'h00) begin
            n = 0;
        end else if (c == 8'h01) begin
            n = MEM;
        end else if (c == 8'h02 && a < MEM) begin
            n = (l > MEM) ? MEM : l;
            s = a;
        end else begin
            e = 1'b1;
        end
    endfunction

    task automatic run_cmd(input logic [7:0] c, input int a,
                           input logic [7:0] d, input int l,
                           input int busy_at, input int exp_n,
                           input int exp_s, input bit exp_e,
                           input string tag);
        int got_n, got_done, got_err, bad, both;
        int first_ev, done_cyc, last;
        logic [7:0] exp_d;
        got_n = 0; got_done = 0; got_err = 0; bad = 0; both = 0;
        first_ev = -1; done_cyc = -1;
        exp_d = (c == 8'h01) ? CLR : d;
        last = exp_n + busy_at + 14;
        @(negedge clk);
        command = c;
        user_addr = a[15:0];
        fill_data = d;
        fill_len = l[15:0];
        request = 1'b1;
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(posedge clk);
            #1;
            if (mem_wren) begin
                if (mem_addr !== 16'((exp_s + got_n) % MEM) ||
                    mem_data !== exp_d) bad++;
                got_n++;
            end
            if (mem_wren !== active) bad++;
            if (first_ev < 0 && (mem_wren || done || err)) first_ev = cyc;
            if (done) begin
                got_done++;
                done_cyc = cyc;
            end
            if (err) got_err++;
            if (done && err) both++;
            if (cyc == 4) request = 1'b0;
            if (cyc == 5) begin
                command = 8'($urandom);
                user_addr = 16'($urandom);
                fill_data = 8'($urandom);
                fill_len = 16'($urandom);
            end
            if (busy_at > 0 && cyc == busy_at) request = 1'b1;
            if (busy_at > 0 && cyc == busy_at + 4) request = 1'b0;
        end
        chk({tag, " writes"}, got_n, exp_n);
        chk({tag, " addr_data_bad"}, bad, 0);
        chk({tag, " done_pulses"}, got_done, exp_e ? 0 : 1);
        chk({tag, " err_pulses"}, got_err, int'(exp_e) + (busy_at > 0 ? 1 : 0));
        chk({tag, " done_cycle"}, done_cyc, exp_e ? -1 : 4 + exp_n);
        chk({tag, " first_event"}, first_ev, 4);
        chk({tag, " done_err_overlap"}, both, 0);
    endtask

    initial begin
        vec_t vecs[$];
        int   acts, wr;
        int   n, s, a, l, busy;
        bit   e;
        logic [7:0] c;

        vecs.push_back('{8'h00, 0,    8'h00, 0,    0,   0,    0,    1'b0});
        vecs.push_back('{8'h01, 5,    8'h55, 7,    0,   2400, 0,    1'b0});
        vecs.push_back('{8'h02, 2398, 8'hAB, 5,    0,   5,    2398, 1'b0});
        vecs.push_back('{8'h02, 100,  8'h11, 0,    0,   0,    0,    1'b0});
        vecs.push_back('{8'h7F, 0,    8'h00, 3,    0,   0,    0,    1'b1});
        vecs.push_back('{8'h02, 2400, 8'hCC, 3,    0,   0,    0,    1'b1});
        vecs.push_back('{8'h02, 10,   8'h5A, 3000, 0,   2400, 10,   1'b0});
        vecs.push_back('{8'h02, 2399, 8'h3C, 1,    0,   1,    2399, 1'b0});
        vecs.push_back('{8'h01, 0,    8'h00, 0,    100, 2400, 0,    1'b0});
        vecs.push_back('{8'h02, 2398, 8'hAB, 5,    5,   5,    2398, 1'b0});
        vecs.push_back('{8'h02, 50,   8'h77, 8,    7,   8,    50,   1'b0});

        rst = 1'b1;
        request = 1'b1;
        command = 8'h01;
        user_addr = '0;
        fill_data = '0;
        fill_len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset mem_addr", int'(mem_addr), 0);
        chk("reset mem_data", int'(mem_data), 0);
        chk("reset wren", int'(mem_wren), 0);
        chk("reset active", int'(active), 0);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);

        rst = 1'b0;
        acts = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (mem_wren || active || done || err) acts++;
        end
        chk("held request across reset", acts, 0);
        request = 1'b0;
        repeat (4) @(posedge clk);

        foreach (vecs[i])
            run_cmd(vecs[i].c, vecs[i].a, vecs[i].d, vecs[i].l,
                    vecs[i].busy, vecs[i].exp_n, vecs[i].exp_s,
                    vecs[i].exp_e, $sformatf("vec%0d", i));

        // Reset lands right after the 100th CLEAR write, request still high.
        wr = 0;
        acts = 0;
        @(negedge clk);
        command = 8'h01;
        request = 1'b1;
        for (int cyc = 1; cyc <= 103; cyc++) begin
            @(posedge clk);
            #1;
            if (mem_wren) wr++;
            if (done || err) acts++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid writes_before", wr, 100);
        chk("rst_mid wren", int'(mem_wren), 0);
        chk("rst_mid active", int'(active), 0);
        chk("rst_mid addr", int'(mem_addr), 0);
        chk("rst_mid done_err", acts + int'(done) + int'(err), 0);
        rst = 1'b0;
        acts = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (mem_wren || active || done || err) acts++;
        end
        chk("rst_mid no_new_cmd", acts, 0);
        request = 1'b0;
        repeat (4) @(posedge clk);

        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 9))
                0:       c = 8'h00;
                1:       c = 8'($urandom_range(3, 255));
                default: c = 8'h02;
            endcase
            a = $urandom_range(0, 2405);
            l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 60);
            if (a >= MEM && l == 0) l = 1;
            model(c, a, l, n, s, e);
            busy = 0;
            if (n >= 4 && $urandom_range(0, 2) == 0)
                busy = $urandom_range(5, n + 1);
            run_cmd(c, a, 8'($urandom), l, busy, n, s, e,
                    $sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
